// File: rtl/uio_arb_pkg.sv
// Shared types and constants for the uio pad arbiter.
//   state_e       : arbiter FSM states
//   DIR_RD/DIR_WR : bus direction encodings (1 = drive pads)
//   OE_ON/OE_OFF  : the only two values the pad enable ever takes
package uio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    XFER = 2'd2
  } state_e;

  localparam logic       DIR_RD = 1'b0;
  localparam logic       DIR_WR = 1'b1;
  localparam logic [7:0] OE_ON  = 8'hFF;
  localparam logic [7:0] OE_OFF = 8'h00;

endpackage

// File: rtl/uio_bus_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector
//   ptr     : highest-priority index this round
//   gnt_oh  : one-hot pick (all zero when no request)
//   gnt_idx : index of the pick (zero when no request)
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_oh,
  output logic [IW-1:0] gnt_idx
);

  logic          found;
  int            k;
  logic [IW-1:0] kk;

  // Scan from ptr upward with wrap; the first asserted request wins.
  always_comb begin
    gnt_oh  = '0;
    gnt_idx = '0;
    found   = 1'b0;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      kk = IW'(k);
      if (!found && req[kk]) begin
        found       = 1'b1;
        gnt_oh[kk]  = 1'b1;
        gnt_idx     = kk;
      end
    end
  end

endmodule

// File: rtl/uio_bus_arbiter.sv
// Shares the bidirectional uio[7:0] pads between NUM_REQ requesters.
// Round-robin grants whole bursts (capped at MAX_BURST beats) and inserts
// TURN_CYC idle cycles with the pads released whenever the bus direction
// changes. Owns the registered uio_out/uio_oe pad drivers.
// Ports:
//   clk_i, rst_i        : clock, synchronous active-high reset
//   req_i/dir_i/last_i  : per-requester beat valid, direction (1=write), last beat
//   wdata_i             : write bytes, requester k at [8k+7:8k]
//   gnt_o               : one-hot grant held for the burst
//   beat_o              : a beat is accepted this cycle
//   rdata_o, rvalid_o   : registered pad sample, valid the cycle after a read beat
//   uio_in_i            : pad input
//   uio_out_o, uio_oe_o : registered pad output and enable
//   busy_o              : FSM not in IDLE
module uio_bus_arbiter
  import uio_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 8,
  parameter int TURN_CYC  = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ-1:0]   dir_i,
  input  logic [NUM_REQ-1:0]   last_i,
  input  logic [NUM_REQ*8-1:0] wdata_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic                 beat_o,
  output logic [7:0]           rdata_o,
  output logic                 rvalid_o,
  input  logic [7:0]           uio_in_i,
  output logic [7:0]           uio_out_o,
  output logic [7:0]           uio_oe_o,
  output logic                 busy_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q;
  logic [IW-1:0]        g_q;
  logic                 dir_q;
  logic                 bus_dir_q;
  logic [CW-1:0]        beat_cnt_q;
  logic [TW-1:0]        turn_cnt_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [7:0]           rdata_q;
  logic                 rvalid_q;
  logic [7:0]           uio_out_q;
  logic [7:0]           uio_oe_q;

  logic [NUM_REQ-1:0]   pick_oh;
  logic [IW-1:0]        pick_idx;
  logic                 beat;
  logic                 burst_end;
  logic [7:0]           wsel;
  logic [IW-1:0]        ptr_next;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    if (c == CW'(MAX_BURST)) return c;
    return c + CW'(1);
  endfunction

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req     (req_i),
    .ptr     (ptr_q),
    .gnt_oh  (pick_oh),
    .gnt_idx (pick_idx)
  );

  assign beat     = |(gnt_q & req_i);
  assign ptr_next = (g_q == IW'(NUM_REQ - 1)) ? '0 : g_q + IW'(1);

  always_comb begin
    wsel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (g_q == IW'(k)) wsel = wdata_i[k*8 +: 8];
    end
  end

  // Next-state: a burst ends on a dropped request, a last beat, or the
  // beat that brings the count to MAX_BURST -- whichever comes first, once.
  always_comb begin
    state_d   = state_q;
    burst_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_i) state_d = (dir_i[pick_idx] != bus_dir_q) ? TURN : XFER;
      end
      TURN: begin
        if (turn_cnt_q == TW'(TURN_CYC - 1)) state_d = XFER;
      end
      XFER: begin
        if (!req_i[g_q] || last_i[g_q] || (sat_inc(beat_cnt_q) == CW'(MAX_BURST))) begin
          burst_end = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      g_q        <= '0;
      dir_q      <= DIR_RD;
      bus_dir_q  <= DIR_RD;
      beat_cnt_q <= '0;
      turn_cnt_q <= '0;
      gnt_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      uio_out_q  <= '0;
      uio_oe_q   <= OE_OFF;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (|req_i) begin
            g_q        <= pick_idx;
            dir_q      <= dir_i[pick_idx];
            turn_cnt_q <= '0;
            beat_cnt_q <= '0;
            if (state_d == XFER) gnt_q <= pick_oh;
          end
        end
        TURN: begin
          turn_cnt_q <= turn_cnt_q + TW'(1);
          if (state_d == XFER) begin
            bus_dir_q <= dir_q;
            gnt_q     <= NUM_REQ'(1) << g_q;
          end
        end
        XFER: begin
          if (beat) beat_cnt_q <= sat_inc(beat_cnt_q);
          if (burst_end) begin
            gnt_q <= '0;
            ptr_q <= ptr_next;
          end
        end
        default: gnt_q <= '0;
      endcase

      // Pad stage: beat data lands on the pads/read register one cycle later.
      rvalid_q <= beat && (bus_dir_q == DIR_RD);
      if (beat && (bus_dir_q == DIR_RD)) rdata_q <= uio_in_i;
      if (beat && (bus_dir_q == DIR_WR)) begin
        uio_out_q <= wsel;
        uio_oe_q  <= OE_ON;
      end else begin
        uio_oe_q  <= OE_OFF;
      end
    end
  end

  assign gnt_o     = gnt_q;
  assign beat_o    = beat;
  assign rdata_o   = rdata_q;
  assign rvalid_o  = rvalid_q;
  assign uio_out_o = uio_out_q;
  assign uio_oe_o  = uio_oe_q;
  assign busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_uio_bus_arbiter.sv
// Scoreboard bench for uio_bus_arbiter: a requester model drives bursts,
// directed tests push expected grant/write/read events, a monitor pops them.
module tb_uio_bus_arbiter;

  localparam int N = 4;
  localparam int EV_GNT = 0;
  localparam int EV_WR  = 1;
  localparam int EV_RD  = 2;

  logic           clk = 1'b0;
  logic           rst_i;
  logic [N-1:0]   req_i, dir_i, last_i;
  logic [N*8-1:0] wdata_i;
  logic [N-1:0]   gnt_o;
  logic           beat_o;
  logic [7:0]     rdata_o;
  logic           rvalid_o;
  logic [7:0]     uio_in_i;
  logic [7:0]     uio_out_o;
  logic [7:0]     uio_oe_o;
  logic           busy_o;

  uio_bus_arbiter #(.NUM_REQ(N), .MAX_BURST(8), .TURN_CYC(1)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .dir_i(dir_i), .last_i(last_i),
    .wdata_i(wdata_i), .gnt_o(gnt_o), .beat_o(beat_o), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .uio_in_i(uio_in_i), .uio_out_o(uio_out_o),
    .uio_oe_o(uio_oe_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   rise_q[$];
  int   fall_q[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  int         left_n [N];
  int         idx_n  [N];
  int         blen_n [N];
  logic [7:0] jdata  [N];
  logic       jdir   [N];
  logic [N-1:0] hitv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] v);
    ev_t e;
    e.kind = kind;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] v, input string nm);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected event: actual=%0h required=none", nm, v);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val !== v) begin
        failures++;
        $display("FAIL %s: actual kind=%0d val=%0h required kind=%0d val=%0h",
                 nm, kind, v, e.kind, e.val);
      end
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -999;
  endfunction

  function automatic bit jobs_done();
    for (int k = 0; k < N; k++) if (left_n[k] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic set_job(input int k, input logic d, input int beats, input int blen,
                         input logic [7:0] data);
    jdir[k]   = d;
    left_n[k] = beats;
    idx_n[k]  = 0;
    blen_n[k] = blen;
    jdata[k]  = data;
  endtask

  // Requester model: consumes a beat when its grant and request were both
  // high during the previous cycle, then updates req/last/wdata.
  initial begin
    req_i   = '0;
    dir_i   = '0;
    last_i  = '0;
    wdata_i = '0;
    for (int k = 0; k < N; k++) begin
      left_n[k] = 0; idx_n[k] = 0; blen_n[k] = 0; jdata[k] = 8'h00; jdir[k] = 1'b0;
    end
    forever begin
      @(negedge clk);
      hitv = gnt_o & req_i;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (hitv[k] === 1'b1 && left_n[k] > 0) begin
          left_n[k]--;
          idx_n[k]++;
        end
        req_i[k]  = (left_n[k] > 0);
        dir_i[k]  = jdir[k];
        last_i[k] = (left_n[k] > 0) && (blen_n[k] != 0) && (((idx_n[k] + 1) % blen_n[k]) == 0);
        wdata_i[k*8 +: 8] = jdata[k];
      end
    end
  end

  // Monitor: pops the scoreboard on every grant rise, pad write and read return.
  initial begin
    logic [N-1:0] gnt_prev;
    logic         prev_beat;
    gnt_prev  = '0;
    prev_beat = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("beat_o", {31'd0, beat_o}, {31'd0, |(gnt_o & req_i)});
        chk("oe_legal", {31'd0, (uio_oe_o == 8'hFF) || (uio_oe_o == 8'h00)}, 32'd1);
        if (gnt_o != '0 && gnt_prev == '0) begin
          rise_q.push_back(cyc);
          expect_ev(EV_GNT, {4'b0, gnt_o}, "grant");
        end
        if (gnt_o == '0 && gnt_prev != '0) fall_q.push_back(cyc);
        if (uio_oe_o == 8'hFF) begin
          expect_ev(EV_WR, uio_out_o, "write");
          chk("wr_latency", {31'd0, prev_beat}, 32'd1);
        end
        if (rvalid_o) begin
          expect_ev(EV_RD, rdata_o, "read");
          chk("rd_latency", {31'd0, prev_beat}, 32'd1);
          chk("oe_after_read", {24'd0, uio_oe_o}, 32'd0);
        end
        gnt_prev  = gnt_o;
        prev_beat = |(gnt_o & req_i);
      end
    end
  end

  task automatic do_reset();
    rst_i = 1'b1;
    for (int k = 0; k < N; k++) left_n[k] = 0;
    repeat (2) @(negedge clk);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic settle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (n < 500 && !(jobs_done() && !busy_o && exp_q.size() == 0));
    if (n >= 500) chk("settle_timeout", 32'd0, 32'd1);
  endtask

  task automatic clear_logs();
    rise_q.delete();
    fall_q.delete();
  endtask

  initial begin
    int c0;
    int n;
    rst_i    = 1'b1;
    uio_in_i = 8'h00;
    do_reset();
    chk("rst_gnt",    {28'd0, gnt_o},     32'd0);
    chk("rst_busy",   {31'd0, busy_o},    32'd0);
    chk("rst_oe",     {24'd0, uio_oe_o},  32'd0);
    chk("rst_out",    {24'd0, uio_out_o}, 32'd0);
    chk("rst_rvalid", {31'd0, rvalid_o},  32'd0);
    chk("rst_rdata",  {24'd0, rdata_o},   32'd0);
    mon_en = 1'b1;

    // 1: single write burst from req0, one TURN out of reset
    @(negedge clk); #1;
    clear_logs();
    c0 = cyc;
    set_job(0, 1'b1, 3, 3, 8'hA5);
    push(EV_GNT, 8'h01);
    repeat (3) push(EV_WR, 8'hA5);
    settle();
    chk("t1_gnt_latency", qget(rise_q, 0) - c0, 32'd3);
    chk("t1_burst_len",   qget(fall_q, 0) - qget(rise_q, 0), 32'd3);

    // 2: three writers, 2-beat bursts, grant order 0,1,2,0
    do_reset();
    clear_logs();
    set_job(0, 1'b1, 4, 2, 8'hA0);
    set_job(1, 1'b1, 2, 2, 8'hB1);
    set_job(2, 1'b1, 2, 2, 8'hC2);
    push(EV_GNT, 8'h01); push(EV_WR, 8'hA0); push(EV_WR, 8'hA0);
    push(EV_GNT, 8'h02); push(EV_WR, 8'hB1); push(EV_WR, 8'hB1);
    push(EV_GNT, 8'h04); push(EV_WR, 8'hC2); push(EV_WR, 8'hC2);
    push(EV_GNT, 8'h01); push(EV_WR, 8'hA0); push(EV_WR, 8'hA0);
    settle();
    for (int i = 0; i < 4; i++) chk("t2_burst_len", qget(fall_q, i) - qget(rise_q, i), 32'd2);
    for (int i = 0; i < 3; i++) chk("t2_idle_gap", qget(rise_q, i + 1) - qget(fall_q, i), 32'd1);

    // 3: req1 holds request with no last: forced release after 8 beats
    clear_logs();
    set_job(1, 1'b1, 9, 0, 8'h3E);
    push(EV_GNT, 8'h02);
    repeat (8) push(EV_WR, 8'h3E);
    push(EV_GNT, 8'h02);
    push(EV_WR, 8'h3E);
    settle();
    chk("t3_max_burst", qget(fall_q, 0) - qget(rise_q, 0), 32'd8);
    chk("t3_regrant",   qget(rise_q, 1) - qget(fall_q, 0), 32'd1);
    chk("t3_drop_len",  qget(fall_q, 1) - qget(rise_q, 1), 32'd2);

    // 4: write burst from req0, then read from req3 across a TURN
    clear_logs();
    set_job(0, 1'b1, 2, 2, 8'h11);
    push(EV_GNT, 8'h01); push(EV_WR, 8'h11); push(EV_WR, 8'h11);
    push(EV_GNT, 8'h08); push(EV_RD, 8'h3C);
    for (n = 0; n < 50 && gnt_o !== 4'b0001; n++) begin @(negedge clk); #1; end
    if (n >= 50) chk("t4_wait_gnt", 32'd0, 32'd1);
    uio_in_i = 8'h3C;
    set_job(3, 1'b0, 1, 1, 8'h00);
    for (n = 0; n < 50 && gnt_o !== 4'b0000; n++) begin @(negedge clk); #1; end
    if (n >= 50) chk("t4_wait_release", 32'd0, 32'd1);
    @(negedge clk); #1;
    chk("t4_turn_oe",   {24'd0, uio_oe_o}, 32'd0);
    chk("t4_turn_gnt",  {28'd0, gnt_o},    32'd0);
    chk("t4_turn_busy", {31'd0, busy_o},   32'd1);
    settle();
    chk("t4_turn_gap", qget(rise_q, 1) - qget(fall_q, 0), 32'd2);

    // 5: req2 drops mid-burst, pending reader req3 follows
    clear_logs();
    uio_in_i = 8'h5A;
    set_job(2, 1'b1, 2, 0, 8'h77);
    set_job(3, 1'b0, 1, 1, 8'h00);
    push(EV_GNT, 8'h04); push(EV_WR, 8'h77); push(EV_WR, 8'h77);
    push(EV_GNT, 8'h08); push(EV_RD, 8'h5A);
    settle();
    chk("t5_drop_release", qget(fall_q, 0) - qget(rise_q, 0), 32'd3);
    chk("t5_next_grant",   qget(rise_q, 1) - qget(fall_q, 0), 32'd2);

    // 6: reset on beat 2 of a write burst, then pointer back at 0
    clear_logs();
    set_job(0, 1'b1, 4, 0, 8'hC3);
    push(EV_GNT, 8'h01); push(EV_WR, 8'hC3);
    for (n = 0; n < 50 && gnt_o !== 4'b0001; n++) begin @(negedge clk); #1; end
    if (n >= 50) chk("t6_wait_gnt", 32'd0, 32'd1);
    @(negedge clk); #1;
    rst_i = 1'b1;
    left_n[0] = 0;
    @(negedge clk); #1;
    chk("t6_rst_gnt",    {28'd0, gnt_o},     32'd0);
    chk("t6_rst_oe",     {24'd0, uio_oe_o},  32'd0);
    chk("t6_rst_out",    {24'd0, uio_out_o}, 32'd0);
    chk("t6_rst_rvalid", {31'd0, rvalid_o},  32'd0);
    chk("t6_rst_rdata",  {24'd0, rdata_o},   32'd0);
    chk("t6_rst_busy",   {31'd0, busy_o},    32'd0);
    chk("t6_sb_empty",   exp_q.size(),       32'd0);
    rst_i = 1'b0;
    clear_logs();
    set_job(0, 1'b1, 1, 1, 8'h01);
    set_job(1, 1'b1, 1, 1, 8'h02);
    push(EV_GNT, 8'h01); push(EV_WR, 8'h01);
    push(EV_GNT, 8'h02); push(EV_WR, 8'h02);
    settle();
    chk("t6_idle_gap", qget(rise_q, 1) - qget(fall_q, 0), 32'd1);

    repeat (3) @(negedge clk);
    chk("sb_drain", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
